// File: rtl/mask_upsample_reader.sv
// Read side of the downsampled mask: follows the display raster, issues mask BRAM
// reads and returns the nearest-neighbour upsampled bit aligned with hcount/vcount.
module mask_upsample_reader #(
   parameter  int FILTER_SIZE  = 5,
   parameter  int CAM_WIDTH    = 240,
   parameter  int CAM_HEIGHT   = 320,
   parameter  int X_ORIGIN     = 0,
   parameter  int Y_ORIGIN     = 0,
   parameter  int BRAM_LATENCY = 2,
   localparam int DS_WIDTH     = CAM_WIDTH / FILTER_SIZE,
   localparam int DS_HEIGHT    = CAM_HEIGHT / FILTER_SIZE,
   localparam int ADDR_W       = $clog2(DS_WIDTH * DS_HEIGHT)
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic              valid_in,
   output logic [ADDR_W-1:0] bram_addr_out,
   input  logic              bram_data_in,
   output logic              mask_out,
   output logic              in_region_out,
   output logic [10:0]       hcount_out,
   output logic [9:0]        vcount_out,
   output logic              valid_out
);

   localparam int REGION_W = DS_WIDTH * FILTER_SIZE;
   localparam int REGION_H = DS_HEIGHT * FILTER_SIZE;
   localparam int SUB_W    = $clog2(FILTER_SIZE + 1);
   localparam int COL_W    = $clog2(DS_WIDTH + 1);
   localparam int ROW_W    = $clog2(DS_HEIGHT + 1);

   typedef struct packed {
      logic        in_region;
      logic        valid;
      logic [10:0] hcount;
      logic [9:0]  vcount;
   } pix_t;

   logic [SUB_W-1:0]  r_sub_x, r_sub_y;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_row_base, r_addr;
   logic [9:0]        r_last_v;
   pix_t              r_pipe [0:BRAM_LATENCY];

   logic [11:0]       w_dx;
   logic [10:0]       w_dy;
   logic              w_in_x, w_in_y, w_in_region, w_line_start, w_first_line;
   logic [SUB_W-1:0]  w_sub_x_cur, w_sub_x_nx, w_sub_y_nx;
   logic [COL_W-1:0]  w_col_cur, w_col_nx;
   logic [ROW_W-1:0]  w_row_nx;
   logic [ADDR_W-1:0] w_base_nx, w_addr;

   // Signed offsets into the window; the borrow bit flags pixels left of / above it.
   assign w_dx         = {1'b0, hcount_in} - 12'(X_ORIGIN);
   assign w_dy         = {1'b0, vcount_in} - 11'(Y_ORIGIN);
   assign w_in_x       = !w_dx[11] && (w_dx[10:0] < 11'(REGION_W));
   assign w_in_y       = !w_dy[10] && (w_dy[9:0] < 10'(REGION_H));
   assign w_in_region  = valid_in && w_in_x && w_in_y;
   assign w_line_start = valid_in && (hcount_in == 11'(X_ORIGIN));
   assign w_first_line = (vcount_in == 10'(Y_ORIGIN));

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_sub_y_nx = r_sub_y;
      w_row_nx   = r_row;
      w_base_nx  = r_row_base;
      if (w_line_start) begin
         if (w_first_line) begin
            w_sub_y_nx = '0;
            w_row_nx   = '0;
            w_base_nx  = '0;
         end else if (w_in_y && (vcount_in != r_last_v)) begin
            if (r_sub_y == SUB_W'(FILTER_SIZE - 1)) begin
               w_sub_y_nx = '0;
               w_row_nx   = r_row + 1'b1;
               w_base_nx  = r_row_base + ADDR_W'(DS_WIDTH);
            end else begin
               w_sub_y_nx = r_sub_y + 1'b1;
            end
         end
      end
   end

   // The first pixel of a line behaves as if the column counters were already zero.
   assign w_sub_x_cur = w_line_start ? '0 : r_sub_x;
   assign w_col_cur   = w_line_start ? '0 : r_col;

   always_comb begin
      w_sub_x_nx = r_sub_x;
      w_col_nx   = r_col;
      if (w_line_start || w_in_region) begin
         if (w_sub_x_cur == SUB_W'(FILTER_SIZE - 1)) begin
            w_sub_x_nx = '0;
            w_col_nx   = w_col_cur + 1'b1;
         end else begin
            w_sub_x_nx = w_sub_x_cur + 1'b1;
            w_col_nx   = w_col_cur;
         end
      end
   end

   assign w_addr = w_base_nx + ADDR_W'(w_col_cur);

   always_ff @(posedge clk_in) begin
      // NOTE: the delay line is reset along with the counters so no stale pixel leaks out after reset.
      if (!rst_n_in) begin
         r_sub_x    <= '0;
         r_sub_y    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_last_v   <= '0;
         for (int i = 0; i <= BRAM_LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         // NOTE: non-blocking throughout, so each delay stage captures the previous stage's old value.
         r_sub_x    <= w_sub_x_nx;
         r_col      <= w_col_nx;
         r_sub_y    <= w_sub_y_nx;
         r_row      <= w_row_nx;
         r_row_base <= w_base_nx;
         if (w_line_start) r_last_v <= vcount_in;
         if (w_in_region)  r_addr   <= w_addr;
         r_pipe[0] <= '{in_region: w_in_region, valid: valid_in,
                        hcount: hcount_in, vcount: vcount_in};
         for (int i = 1; i <= BRAM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign bram_addr_out = r_addr;
   assign mask_out      = bram_data_in & r_pipe[BRAM_LATENCY].in_region;
   assign in_region_out = r_pipe[BRAM_LATENCY].in_region;
   assign valid_out     = r_pipe[BRAM_LATENCY].valid;
   assign hcount_out    = r_pipe[BRAM_LATENCY].hcount;
   assign vcount_out    = r_pipe[BRAM_LATENCY].vcount;

endmodule

// File: tb/tb_mask_upsample_reader.sv
// Bench for mask_upsample_reader: three configurations, behavioural BRAM models and a
// scoreboard of expected outputs built from a divide-based address model.
module tb_mask_upsample_reader;

   typedef struct packed {
      logic        vld;
      logic        inr;
      logic [10:0] h;
      logic [9:0]  v;
      logic        mask;
   } exp_t;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic        vl;
   } stim_t;

   typedef struct packed {
      logic        vld;
      logic        inr;
      logic        mask;
      logic [10:0] h;
      logic [9:0]  v;
      logic [11:0] addr;
   } obs_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] h_in   [3];
   logic [9:0]  v_in   [3];
   logic        vld_in [3];
   logic        d1 [3];
   logic        d2 [2];

   logic [11:0] a_addr, b_addr;
   logic [3:0]  c_addr;
   logic        a_mask, b_mask, c_mask, a_inr, b_inr, c_inr, a_vld, b_vld, c_vld;
   logic [10:0] a_h, b_h, c_h;
   logic [9:0]  a_v, b_v, c_v;

   int p_fs  [3] = '{5, 5, 1};
   int p_dsw [3] = '{48, 48, 4};
   int p_dsh [3] = '{64, 64, 4};
   int p_xo  [3] = '{0, 100, 0};
   int p_yo  [3] = '{0, 50, 0};
   int p_lat [3] = '{3, 3, 2};

   int    mode;        // 0: address parity, 1: all ones, 2: row^col board
   int    m_addr [3];
   int    n_vec = 0;
   int    n_err = 0;
   exp_t  q [$];
   stim_t s [$];

   always #5 clk = ~clk;

   mask_upsample_reader u_a (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(h_in[0]), .vcount_in(v_in[0]),
      .valid_in(vld_in[0]), .bram_addr_out(a_addr), .bram_data_in(d2[0]), .mask_out(a_mask),
      .in_region_out(a_inr), .hcount_out(a_h), .vcount_out(a_v), .valid_out(a_vld));

   mask_upsample_reader #(.X_ORIGIN(100), .Y_ORIGIN(50)) u_b (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(h_in[1]), .vcount_in(v_in[1]),
      .valid_in(vld_in[1]), .bram_addr_out(b_addr), .bram_data_in(d2[1]), .mask_out(b_mask),
      .in_region_out(b_inr), .hcount_out(b_h), .vcount_out(b_v), .valid_out(b_vld));

   mask_upsample_reader #(.FILTER_SIZE(1), .CAM_WIDTH(4), .CAM_HEIGHT(4), .BRAM_LATENCY(1)) u_c (
      .clk_in(clk), .rst_n_in(rst_n), .hcount_in(h_in[2]), .vcount_in(v_in[2]),
      .valid_in(vld_in[2]), .bram_addr_out(c_addr), .bram_data_in(d1[2]), .mask_out(c_mask),
      .in_region_out(c_inr), .hcount_out(c_h), .vcount_out(c_v), .valid_out(c_vld));

   function automatic logic mem_bit(input int k, input int a);
      case (mode)
         0:       return ^a;
         1:       return 1'b1;
         default: return (((a / p_dsw[k]) ^ (a % p_dsw[k])) & 1) != 0;
      endcase
   endfunction

   function automatic obs_t obs(input int k);
      case (k)
         0:       return '{a_vld, a_inr, a_mask, a_h, a_v, a_addr};
         1:       return '{b_vld, b_inr, b_mask, b_h, b_v, b_addr};
         default: return '{c_vld, c_inr, c_mask, c_h, c_v, {8'd0, c_addr}};
      endcase
   endfunction

   // Mask BRAMs: two-cycle read for u_a/u_b, one-cycle read for u_c.
   always @(posedge clk) begin
      d1[0] <= mem_bit(0, int'(a_addr));
      d1[1] <= mem_bit(1, int'(b_addr));
      d1[2] <= mem_bit(2, int'(c_addr));
      d2[0] <= d1[0];
      d2[1] <= d1[1];
   end

   task automatic drive(input int k, input int x, input int y, input logic vl);
      exp_t e;
      int   rx, ry;
      logic inr;
      h_in[k]   = 11'(x);
      v_in[k]   = 10'(y);
      vld_in[k] = vl;
      rx  = x - p_xo[k];
      ry  = y - p_yo[k];
      inr = vl && rx >= 0 && rx < p_dsw[k] * p_fs[k] && ry >= 0 && ry < p_dsh[k] * p_fs[k];
      if (inr) m_addr[k] = (ry / p_fs[k]) * p_dsw[k] + rx / p_fs[k];
      e.vld  = vl;
      e.inr  = inr;
      e.h    = 11'(x);
      e.v    = 10'(y);
      e.mask = inr && mem_bit(k, m_addr[k]);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic add_line(input int y, input int x0, input int x1, input int gap);
      for (int x = x0; x <= x1; x++) s.push_back('{11'(x), 10'(y), 1'b1});
      for (int g = 0; g < gap; g++) s.push_back('{11'(x1 + 1 + g), 10'(y), 1'b0});
   endtask

   task automatic add_drain(input int n);
      for (int i = 0; i < n; i++) s.push_back('{11'd0, 10'd0, 1'b0});
   endtask

   task automatic test_reset;
      obs_t o;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         o = obs(k);
         n_vec++;
         if (o !== '0) begin
            n_err++;
            $display("FAIL reset_state dut%0d: got %h, expected 0", k, o);
         end
      end
      rst_n = 1'b1;
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 30; x++) begin
            rst_n = !(y == 1 && x >= 20 && x < 24);
            drive(0, x, y, 1'b1);
            o = obs(0);
            if (!rst_n) begin
               n_vec++;
               if (o !== '0) begin
                  n_err++;
                  $display("FAIL reset_hold x=%0d: got %h, expected 0", x, o);
               end
            end else if (y == 1 && (x == 24 || x == 25)) begin
               n_vec++;
               if ({o.vld, o.inr, o.mask} !== 3'b000) begin
                  n_err++;
                  $display("FAIL reset_release x=%0d: got vld=%0b reg=%0b mask=%0b, expected 000",
                           x, o.vld, o.inr, o.mask);
               end
            end else if (y == 1 && x == 26) begin
               n_vec++;
               if ({o.vld, o.inr, o.h, o.v} !== {1'b1, 1'b1, 11'd24, 10'd1}) begin
                  n_err++;
                  $display("FAIL reset_first_pixel: got vld=%0b reg=%0b h=%0d v=%0d, expected 1 1 24 1",
                           o.vld, o.inr, o.h, o.v);
               end
            end
         end
      end
      rst_n = 1'b0;
      drive(0, 0, 0, 1'b0);
      drive(0, 0, 0, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) m_addr[k] = 0;
      q.delete();
   endtask

   task automatic test_full_scan;
      obs_t o;
      exp_t e;
      mode = 0;
      s.delete();
      for (int y = 0; y < 320; y++) begin
         if (y == 0 || y == 4 || y == 5 || y == 319) add_line(y, 0, 241, 2);
         else add_line(y, 0, 9, 2);
      end
      add_drain(p_lat[0]);
      for (int i = 0; i < s.size(); i++) begin
         drive(0, int'(s[i].x), int'(s[i].y), s[i].vl);
         o = obs(0);
         n_vec++;
         if (o.addr !== 12'(m_addr[0])) begin
            n_err++;
            $display("FAIL scan_addr x=%0d y=%0d: got %0d, expected %0d", s[i].x, s[i].y, o.addr, m_addr[0]);
         end
         if (q.size() >= p_lat[0]) begin
            e = q.pop_front();
            n_vec++;
            if ({o.vld, o.inr, o.mask, o.h, o.v} !== {e.vld, e.inr, e.mask, e.h, e.v}) begin
               n_err++;
               $display("FAIL scan_out h=%0d v=%0d: got vld=%0b reg=%0b mask=%0b h=%0d v=%0d, expected vld=%0b reg=%0b mask=%0b",
                        e.h, e.v, o.vld, o.inr, o.mask, o.h, o.v, e.vld, e.inr, e.mask);
            end
         end
      end
      q.delete();
   endtask

   task automatic test_board_blanking;
      obs_t o;
      exp_t e;
      mode = 2;
      s.delete();
      for (int y = 0; y < 12; y++) begin
         add_line(y, 0, 14, 60);
         if (y == 7) add_line(y, 0, 14, 60);
      end
      for (int y = 320; y < 340; y++) begin
         for (int g = 0; g < 5; g++) s.push_back('{11'd0, 10'(y), 1'b0});
      end
      for (int y = 0; y < 7; y++) add_line(y, 0, 14, 60);
      add_drain(p_lat[0]);
      for (int i = 0; i < s.size(); i++) begin
         drive(0, int'(s[i].x), int'(s[i].y), s[i].vl);
         o = obs(0);
         n_vec++;
         if (o.addr !== 12'(m_addr[0])) begin
            n_err++;
            $display("FAIL board_addr x=%0d y=%0d: got %0d, expected %0d", s[i].x, s[i].y, o.addr, m_addr[0]);
         end
         if (q.size() >= p_lat[0]) begin
            e = q.pop_front();
            n_vec++;
            if ({o.vld, o.inr, o.mask, o.h, o.v} !== {e.vld, e.inr, e.mask, e.h, e.v}) begin
               n_err++;
               $display("FAIL board_out h=%0d v=%0d: got vld=%0b reg=%0b mask=%0b h=%0d v=%0d, expected vld=%0b reg=%0b mask=%0b",
                        e.h, e.v, o.vld, o.inr, o.mask, o.h, o.v, e.vld, e.inr, e.mask);
            end
         end
      end
      q.delete();
   endtask

   task automatic test_origin;
      obs_t o;
      exp_t e;
      mode = 1;
      s.delete();
      for (int y = 48; y < 372; y++) begin
         if (y == 49 || y == 50 || y == 51 || y == 200 || y == 369 || y == 370) add_line(y, 98, 341, 3);
         else add_line(y, 98, 104, 3);
      end
      add_drain(p_lat[1]);
      for (int i = 0; i < s.size(); i++) begin
         drive(1, int'(s[i].x), int'(s[i].y), s[i].vl);
         o = obs(1);
         n_vec++;
         if (o.addr !== 12'(m_addr[1])) begin
            n_err++;
            $display("FAIL origin_addr x=%0d y=%0d: got %0d, expected %0d", s[i].x, s[i].y, o.addr, m_addr[1]);
         end
         if (q.size() >= p_lat[1]) begin
            e = q.pop_front();
            n_vec++;
            if ({o.vld, o.inr, o.mask, o.h, o.v} !== {e.vld, e.inr, e.mask, e.h, e.v}) begin
               n_err++;
               $display("FAIL origin_out h=%0d v=%0d: got vld=%0b reg=%0b mask=%0b h=%0d v=%0d, expected vld=%0b reg=%0b mask=%0b",
                        e.h, e.v, o.vld, o.inr, o.mask, o.h, o.v, e.vld, e.inr, e.mask);
            end
         end
      end
      q.delete();
   endtask

   task automatic test_unit_filter;
      obs_t o;
      exp_t e;
      mode = 0;
      s.delete();
      for (int y = 0; y < 5; y++) add_line(y, 0, 5, 1);
      add_drain(p_lat[2]);
      for (int i = 0; i < s.size(); i++) begin
         drive(2, int'(s[i].x), int'(s[i].y), s[i].vl);
         o = obs(2);
         n_vec++;
         if (o.addr !== 12'(m_addr[2])) begin
            n_err++;
            $display("FAIL unit_addr x=%0d y=%0d: got %0d, expected %0d", s[i].x, s[i].y, o.addr, m_addr[2]);
         end
         if (q.size() >= p_lat[2]) begin
            e = q.pop_front();
            n_vec++;
            if ({o.vld, o.inr, o.mask, o.h, o.v} !== {e.vld, e.inr, e.mask, e.h, e.v}) begin
               n_err++;
               $display("FAIL unit_out h=%0d v=%0d: got vld=%0b reg=%0b mask=%0b h=%0d v=%0d, expected vld=%0b reg=%0b mask=%0b",
                        e.h, e.v, o.vld, o.inr, o.mask, o.h, o.v, e.vld, e.inr, e.mask);
            end
         end
      end
      q.delete();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         h_in[k]   = '0;
         v_in[k]   = '0;
         vld_in[k] = 1'b0;
         m_addr[k] = 0;
      end
      mode = 0;
      test_reset();
      test_full_scan();
      test_board_blanking();
      test_origin();
      test_unit_filter();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
